// File: rtl/morse_sequencer_pkg.sv
// Shared types and constants for the Morse character sequencer.
package morse_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MARK  = 3'd1,
        S_SPACE = 3'd2,
        S_TAIL  = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    localparam logic [1:0] PAIR_DOT  = 2'b10;
    localparam logic [1:0] PAIR_DASH = 2'b11;
    localparam int         SLOTS     = 5;
    localparam logic [2:0] LAST_SLOT = 3'(SLOTS - 1);

    // A pair with its upper bit clear terminates the character.
    function automatic logic pair_valid(input logic [1:0] p);
        return p[1];
    endfunction

endpackage

// File: rtl/morse_sequencer_if.sv
// Character-source side of the sequencer: request, character and the timed key outputs.
interface morse_sequencer_if;
    logic       start;
    logic       abort;
    logic [9:0] code;
    logic       busy;
    logic       done;
    logic       led;
    logic       short;
    logic       long;
    logic [2:0] sym_idx;

    modport master (output start, abort, code,
                    input  busy, done, led, short, long, sym_idx);
    modport slave  (input  start, abort, code,
                    output busy, done, led, short, long, sym_idx);
endinterface

// File: rtl/morse_sequencer_tick.sv
// Unit-time prescaler: one-cycle tick every TICK_DIV clocks, realigned by clr.
module morse_tick_gen #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] count;

    assign tick = (count == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)            count <= '0;
        else if (clr || tick)  count <= '0;
        else                   count <= count + CW'(1);
    end
endmodule

// File: rtl/morse_sequencer.sv
// Plays one latched 5-slot Morse character as timed marks/spaces with a trailing gap.
module morse_sequencer
    import morse_sequencer_pkg::*;
#(
    parameter int TICK_DIV   = 25000000,
    parameter int DASH_UNITS = 3,
    parameter int GAP_UNITS  = 3
) (
    input  logic              clk,
    input  logic              reset,
    morse_sequencer_if.slave  bus
);
    localparam int UMAX = (DASH_UNITS > GAP_UNITS) ? DASH_UNITS : GAP_UNITS;
    localparam int UW   = $clog2(UMAX + 1);
    localparam logic [UW-1:0] U_ONE  = UW'(1);
    localparam logic [UW-1:0] U_DASH = UW'(DASH_UNITS);
    localparam logic [UW-1:0] U_GAP  = UW'(GAP_UNITS);

    state_t        state, state_n;
    logic [9:0]    code_q, code_n;
    logic [UW-1:0] units, units_n;
    logic [2:0]    idx, idx_n;
    logic          busy_q, busy_n, done_q, done_n;
    logic          led_q, led_n, short_q, short_n, long_q, long_n;
    logic          clr, tick;

    morse_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .tick  (tick)
    );

    function automatic logic [UW-1:0] mark_len(input logic [1:0] p);
        return (p == PAIR_DASH) ? U_DASH : U_ONE;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            code_q  <= '0;
            units   <= '0;
            idx     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            led_q   <= 1'b0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            state   <= state_n;
            code_q  <= code_n;
            units   <= units_n;
            idx     <= idx_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            led_q   <= led_n;
            short_q <= short_n;
            long_q  <= long_n;
        end
    end

    always_comb begin
        state_n = state;
        code_n  = code_q;
        units_n = units;
        idx_n   = idx;
        busy_n  = busy_q;
        done_n  = 1'b0;
        led_n   = led_q;
        short_n = short_q;
        long_n  = long_q;
        clr     = 1'b0;
        if (bus.abort && busy_q) begin
            state_n = S_IDLE;
            busy_n  = 1'b0;
            led_n   = 1'b0;
            short_n = 1'b0;
            long_n  = 1'b0;
            idx_n   = '0;
        end else if (bus.start && !busy_q && !bus.abort) begin
            clr     = 1'b1;
            code_n  = bus.code;
            idx_n   = '0;
            busy_n  = 1'b1;
            led_n   = pair_valid(bus.code[9:8]);
            short_n = (bus.code[9:8] == PAIR_DOT);
            long_n  = (bus.code[9:8] == PAIR_DASH);
            units_n = mark_len(bus.code[9:8]);
            state_n = pair_valid(bus.code[9:8]) ? S_MARK : S_FIN;
        end else begin
            case (state)
                S_MARK: if (tick) begin
                    if (units == U_ONE) begin
                        led_n   = 1'b0;
                        short_n = 1'b0;
                        long_n  = 1'b0;
                        if (pair_valid(code_q[7:6]) && idx < LAST_SLOT) begin
                            state_n = S_SPACE;
                        end else begin
                            state_n = S_TAIL;
                            units_n = U_GAP;
                        end
                    end else begin
                        units_n = units - U_ONE;
                    end
                end
                S_SPACE: if (tick) begin
                    state_n = S_MARK;
                    code_n  = {code_q[7:0], 2'b00};
                    idx_n   = idx + 3'd1;
                    led_n   = 1'b1;
                    short_n = (code_q[7:6] == PAIR_DOT);
                    long_n  = (code_q[7:6] == PAIR_DASH);
                    units_n = mark_len(code_q[7:6]);
                end
                S_TAIL: if (tick) begin
                    if (units == U_ONE) begin
                        state_n = S_FIN;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        idx_n   = '0;
                    end else begin
                        units_n = units - U_ONE;
                    end
                end
                S_FIN: begin
                    // Reached either from the tail (done already pulsed) or from an empty character.
                    state_n = S_IDLE;
                    busy_n  = 1'b0;
                    done_n  = !done_q;
                    idx_n   = '0;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.led     = led_q;
    assign bus.short   = short_q;
    assign bus.long    = long_q;
    assign bus.sym_idx = idx;
endmodule

// File: tb/tb_morse_sequencer.sv
// Two sequencers (TICK_DIV 4 and 1) on shared stimulus, checked every cycle against a timeline model.
module tb_morse_sequencer;
    localparam int DASH = 3;
    localparam int GAP  = 3;
    localparam logic [9:0] C1 = 10'b10_11_00_00_00;
    localparam logic [9:0] C2 = 10'b11_11_11_11_11;
    localparam logic [9:0] C3 = 10'b00_10_10_10_10;

    logic clk = 1'b0, rst_n = 1'b0;
    logic st = 1'b0, ab = 1'b0;
    logic [9:0] cd = '0;
    int total = 0, bad = 0, cyc = 0, e0 = 0;
    int divs[2] = '{4, 1};
    bit ma[2];
    int mk[2];
    logic [9:0] mc[2];

    morse_sequencer_if if4();
    morse_sequencer_if if1();
    assign if4.start = st;
    assign if4.abort = ab;
    assign if4.code  = cd;
    assign if1.start = st;
    assign if1.abort = ab;
    assign if1.code  = cd;

    morse_sequencer #(.TICK_DIV(4), .DASH_UNITS(DASH), .GAP_UNITS(GAP)) dut4 (
        .clk(clk), .reset(rst_n), .bus(if4));
    morse_sequencer #(.TICK_DIV(1), .DASH_UNITS(DASH), .GAP_UNITS(GAP)) dut1 (
        .clk(clk), .reset(rst_n), .bus(if1));

    always #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    // Expected {busy,done,led,short,long,sym_idx} k clocks after the acceptance edge.
    function automatic logic [7:0] exp_at(input logic [9:0] c, input int div, input int k);
        int n = 0, t = 0, len;
        for (int i = 0; i < 5; i++) begin
            if (!c[9-2*i]) break;
            n++;
        end
        if (n == 0) return (k == 0) ? 8'b1000_0000 : (k == 1) ? 8'b0100_0000 : 8'h00;
        for (int i = 0; i < n; i++) begin
            logic dash;
            dash = c[8-2*i];
            len  = (dash ? DASH : 1) * div;
            if (k < t + len) return {1'b1, 1'b0, 1'b1, !dash, dash, 3'(i)};
            t += len;
            if (i < n - 1) begin
                if (k < t + div) return {5'b10000, 3'(i)};
                t += div;
            end
        end
        if (k < t + GAP * div) return {5'b10000, 3'(n - 1)};
        if (k == t + GAP * div) return 8'b0100_0000;
        return 8'h00;
    endfunction

    function automatic logic [7:0] dut_out(input int d);
        if (d == 0) return {if4.busy, if4.done, if4.led, if4.short, if4.long, if4.sym_idx};
        return {if1.busy, if1.done, if1.led, if1.short, if1.long, if1.sym_idx};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks acceptance/abort and the elapsed clocks of the current character.
    initial forever begin
        logic [7:0] cur;
        @(posedge clk or negedge rst_n);
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) ma[d] = 1'b0;
            else begin
                cur = ma[d] ? exp_at(mc[d], divs[d], mk[d]) : 8'h00;
                if (ab && cur[7]) ma[d] = 1'b0;
                else if (st && !ab && !cur[7]) begin
                    ma[d] = 1'b1; mk[d] = 0; mc[d] = cd;
                end else if (ma[d]) begin
                    mk[d]++;
                    if (exp_at(mc[d], divs[d], mk[d]) == 8'h00) ma[d] = 1'b0;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        check("cycle_div4", dut_out(0), ma[0] ? exp_at(mc[0], 4, mk[0]) : 8'h00);
        check("cycle_div1", dut_out(1), ma[1] ? exp_at(mc[1], 1, mk[1]) : 8'h00);
    end

    task automatic launch(input logic [9:0] c);
        @(negedge clk); st = 1'b1; cd = c;
        @(negedge clk); st = 1'b0; e0 = cyc;
    endtask

    task automatic wait_done(input int d, input int want, input string name);
        int n = 0;
        while (!(d == 0 ? if4.done : if1.done) && n < 400) begin @(negedge clk); n++; end
        check(name, 8'(cyc - e0), 8'(want));
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((ma[0] || ma[1]) && n < 300) begin @(negedge clk); n++; end
        check("idle_bound", {6'b0, ma[0], ma[1]}, 8'h00);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        // model pins, hand-derived from the unit timing
        check("pin_c1_k0",  exp_at(C1, 4, 0),  8'b1011_0000);
        check("pin_c1_k4",  exp_at(C1, 4, 4),  8'b1000_0000);
        check("pin_c1_k8",  exp_at(C1, 4, 8),  8'b1010_1001);
        check("pin_c1_k19", exp_at(C1, 4, 19), 8'b1010_1001);
        check("pin_c1_k20", exp_at(C1, 4, 20), 8'b1000_0001);
        check("pin_c1_k32", exp_at(C1, 4, 32), 8'b0100_0000);
        check("pin_c1_k33", exp_at(C1, 4, 33), 8'h00);
        check("pin_c2_k87", exp_at(C2, 4, 87), 8'b1000_0100);
        check("pin_c2_k88", exp_at(C2, 4, 88), 8'b0100_0000);
        check("pin_c3_k1",  exp_at(C3, 4, 1),  8'b0100_0000);
        check("pin_c1d1_k8", exp_at(C1, 1, 8), 8'b0100_0000);

        repeat (3) @(negedge clk);
        check("reset_div4", dut_out(0), 8'h00);
        check("reset_div1", dut_out(1), 8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // dot-dash, with a start pulse and code change mid-character
        launch(C1);
        repeat (4) @(negedge clk);
        st = 1'b1; cd = C2;
        @(negedge clk); st = 1'b0; cd = C3;
        wait_done(0, 32, "c1_done_at");
        wait_idle();

        launch(C2);
        wait_done(0, 88, "c2_done_at");
        wait_idle();

        launch(C3);
        wait_done(0, 1, "c3_done_at");
        wait_idle();

        // abort during the dash, then a clean restart two edges later
        launch(C1);
        repeat (9) @(negedge clk);
        ab = 1'b1;
        @(negedge clk); ab = 1'b0;
        check("abort_idle", dut_out(0), 8'h00);
        st = 1'b1; cd = C1;
        @(negedge clk); st = 1'b0; e0 = cyc;
        wait_done(0, 32, "restart_done_at");
        wait_idle();

        // async reset between edges while sounding a dash
        launch(C1);
        repeat (9) @(negedge clk);
        check("pre_reset_dash", dut_out(0), 8'b1010_1001);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_div4", dut_out(0), 8'h00);
        check("async_rst_div1", dut_out(1), 8'h00);
        @(negedge clk); rst_n = 1'b1;
        launch(C1);
        wait_done(1, 8, "div1_done_at");
        wait_idle();

        for (int it = 0; it < 40; it++) begin
            @(negedge clk);
            st = 1'b1; cd = 10'($urandom);
            if ($urandom_range(0, 3) != 0) cd[9] = 1'b1;
            len = $urandom_range(20, 120);
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                st = ($urandom_range(0, 15) == 0);
                ab = ($urandom_range(0, 60) == 0);
                cd = 10'($urandom);
            end
            st = 1'b0; ab = 1'b0;
            wait_idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
